mem_arbiter: RTL and testbench

//  Shares the single Hack data-memory port (RAM16K + MMIO LED at 0x4000) between two requesters:

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_rr2.sv | 29 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the Hack data-memory arbiter.
// The arbitration variant is selected by MEM_ARB_FIXED_PRIO_EN (see arb_rr2).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    // 0 = port 0 (CPU), 1 = port 1 (debug/loader)
    typedef logic arb_owner_t;

    localparam logic [15:0] MMIO_LED_ADDR = 16'h4000;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way grant. Round-robin by default; with MEM_ARB_FIXED_PRIO_EN
// defined, port 0 always wins and the last-owner input disappears.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] reqs,
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  arb_owner_t last_owner,
`endif
    output logic       grant,
    output arb_owner_t owner
);

    assign grant = |reqs;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign owner = ~reqs[0];
`else
    always_comb begin
        if (&reqs) begin
            owner = ~last_owner;
        end else begin
            // A lone requester wins regardless of the pointer
            owner = reqs[1];
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter in front of the Hack data memory (RAM16K + MMIO LED).
// Define MEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [DATA_W-1:0] mem_in,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    arb_state_t        state;
    arb_owner_t        owner;
    logic              we_q;
    logic [CNT_W-1:0]  cnt;

    logic              grant;
    arb_owner_t        grant_owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifndef MEM_ARB_FIXED_PRIO_EN
    arb_owner_t        last_owner;
`endif

    arb_rr2 u_arb (
        .reqs       ({m1_req, m0_req}),
`ifndef MEM_ARB_FIXED_PRIO_EN
        .last_owner (last_owner),
`endif
        .grant      (grant),
        .owner      (grant_owner)
    );

    assign sel_we    = grant_owner ? m1_we    : m0_we;
    assign sel_addr  = grant_owner ? m1_addr  : m0_addr;
    assign sel_wdata = grant_owner ? m1_wdata : m0_wdata;
    assign busy      = (state != ARB_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            owner       <= 1'b0;
            we_q        <= 1'b0;
            cnt         <= '0;
            mem_address <= '0;
            mem_in      <= '0;
            mem_load    <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            // "Last granted = port 1" makes port 0 the first choice after reset
            last_owner  <= 1'b1;
`endif
        end else begin
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            mem_load <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        owner       <= grant_owner;
                        we_q        <= sel_we;
                        mem_address <= sel_addr;
                        mem_in      <= sel_wdata;
                        mem_load    <= sel_we;
                        cnt         <= '0;
                        state       <= ARB_ACCESS;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_owner  <= grant_owner;
`endif
                    end
                end
                ARB_ACCESS: begin
                    if (we_q || cnt == CNT_LAST) begin
                        // Read data is sampled on the edge that ends the last ACCESS cycle
                        if (!we_q) begin
                            if (owner) m1_rdata <= mem_out;
                            else       m0_rdata <= mem_out;
                        end
                        if (owner) m1_ack <= 1'b1;
                        else       m0_ack <= 1'b1;
                        state <= ARB_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory; a second instance
// covers RD_LATENCY=3. Honours MEM_ARB_FIXED_PRIO_EN for the arbitration test.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_req, m0_we, m0_ack;
    logic [15:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic [15:0] mem_in, mem_address, mem_out;
    logic        mem_load, busy;

    logic        r3_req, r3_ack, r3_m1_ack, r3_mem_load, r3_busy;
    logic [15:0] r3_addr, r3_rdata, r3_m1_rdata, r3_mem_in, r3_mem_address, r3_mem_out;
    logic        r3_zero_bit;
    logic [15:0] r3_zero_word;

    logic [15:0] ram [0:65535];
    logic        bw_en;
    logic [15:0] bw_addr, bw_data;

    always @(posedge clk) begin
        if (mem_load) ram[mem_address] <= mem_in;
        else if (bw_en) ram[bw_addr] <= bw_data;
    end
    assign mem_out    = ram[mem_address];
    assign r3_mem_out = ram[r3_mem_address];

    mem_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load),
        .mem_out(mem_out), .busy(busy)
    );

    mem_arbiter #(.RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(r3_req), .m0_we(r3_zero_bit), .m0_addr(r3_addr), .m0_wdata(r3_zero_word),
        .m0_ack(r3_ack), .m0_rdata(r3_rdata),
        .m1_req(r3_zero_bit), .m1_we(r3_zero_bit), .m1_addr(r3_zero_word), .m1_wdata(r3_zero_word),
        .m1_ack(r3_m1_ack), .m1_rdata(r3_m1_rdata),
        .mem_in(r3_mem_in), .mem_address(r3_mem_address), .mem_load(r3_mem_load),
        .mem_out(r3_mem_out), .busy(r3_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    int         got;
    logic [1:0] seq [0:5];

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        r3_req = 0; r3_addr = 0; r3_zero_bit = 0; r3_zero_word = 0;
        bw_en = 0; bw_addr = 0; bw_data = 0;

        // Reset and memory preload
        step();
        bw_en = 1; bw_addr = 16'h0020; bw_data = 16'hBEEF;
        step();
        bw_addr = 16'h0040; bw_data = 16'hA5C3;
        step();
        bw_en = 0;
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_mem_load", mem_load, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_in", mem_in, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // 1: m0 write then read back
        m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 16'h1234;
        step();
        chk("t1_busy", busy, 1);
        chk("t1_mem_load", mem_load, 1);
        chk("t1_mem_address", mem_address, 16'h0010);
        chk("t1_mem_in", mem_in, 16'h1234);
        chk("t1_early_ack", m0_ack, 0);
        step();
        chk("t1_wr_ack", m0_ack, 1);
        chk("t1_load_done", mem_load, 0);
        m0_req = 0;
        step();
        chk("t1_ack_pulse", m0_ack, 0);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_addr_hold", mem_address, 16'h0010);
        chk("t1_ram", ram[16'h0010], 16'h1234);
        m0_req = 1; m0_we = 0;
        step();
        chk("t1_rd_no_load", mem_load, 0);
        chk("t1_rd_early_ack", m0_ack, 0);
        step();
        chk("t1_rd_ack", m0_ack, 1);
        chk("t1_rd_data", m0_rdata, 16'h1234);
        m0_req = 0;
        step();

        // 2: simultaneous requests straight after reset
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = MMIO_LED_ADDR; m0_wdata = 16'h00FF;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0020;
        step();
        chk("t2_first_addr", mem_address, 16'h4000);
        chk("t2_first_load", mem_load, 1);
        step();
        chk("t2_m0_ack", m0_ack, 1);
        chk("t2_m1_wait", m1_ack, 0);
        m0_req = 0;
        step();
        chk("t2_done_idle", busy, 0);
        step();
        chk("t2_second_addr", mem_address, 16'h0020);
        chk("t2_second_load", mem_load, 0);
        step();
        chk("t2_m1_ack", m1_ack, 1);
        chk("t2_m0_quiet", m0_ack, 0);
        chk("t2_m1_rdata", m1_rdata, 16'hBEEF);
        chk("t2_led", ram[MMIO_LED_ADDR], 16'h00FF);
        m1_req = 0;
        step();

        // 3: both ports request continuously
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 16'h0020;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0040;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            step();
            if (m0_ack && got < 6) begin seq[got] = 2'd0; got++; end
            if (m1_ack && got < 6) begin seq[got] = 2'd1; got++; end
        end
        m0_req = 0; m1_req = 0;
        chk("t3_count", got, 6);
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk($sformatf("t3_grant%0d", i), seq[i], 2'd0);
`else
            chk($sformatf("t3_grant%0d", i), seq[i], (i % 2 == 0) ? 2'd0 : 2'd1);
`endif
        end
        chk("t3_m0_rdata", m0_rdata, 16'hBEEF);
`ifdef MEM_ARB_FIXED_PRIO_EN
        chk("t3_m1_rdata", m1_rdata, 16'h0000);
`else
        chk("t3_m1_rdata", m1_rdata, 16'hA5C3);
`endif
        step();
        step();

        // 4: reset during a port-1 write access
        m1_req = 1; m1_we = 1; m1_addr = 16'h0030; m1_wdata = 16'h5555;
        step();
        chk("t4_load_pulse", mem_load, 1);
        chk("t4_addr", mem_address, 16'h0030);
        rst_n = 0; m1_req = 0;
        step();
        chk("t4_load_drop", mem_load, 0);
        chk("t4_busy", busy, 0);
        chk("t4_no_ack", m1_ack, 0);
        rst_n = 1;
        step();
        chk("t4_no_ack_late", m1_ack, 0);
        chk("t4_idle_load", mem_load, 0);
        chk("t4_m0_rdata_clr", m0_rdata, 0);

        // 5: port 1 drops req right after being latched
        m1_req = 1; m1_we = 0; m1_addr = 16'h0040;
        step();
        chk("t5_busy", busy, 1);
        m1_req = 0;
        step();
        chk("t5_m1_ack", m1_ack, 1);
        chk("t5_m1_rdata", m1_rdata, 16'hA5C3);
        chk("t5_m0_ack", m0_ack, 0);
        chk("t5_m0_rdata", m0_rdata, 0);
        step();
        chk("t5_ack_once", m1_ack, 0);
        step();
        chk("t5_no_reack", m1_ack, 0);
        chk("t5_idle", busy, 0);

        // 6: RD_LATENCY=3 instance
        r3_req = 1; r3_addr = 16'h0010;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("t6_busy%0d", c), r3_busy, 1);
            chk($sformatf("t6_addr%0d", c), r3_mem_address, 16'h0010);
            chk($sformatf("t6_load%0d", c), r3_mem_load, 0);
            chk($sformatf("t6_early_ack%0d", c), r3_ack, 0);
        end
        step();
        chk("t6_ack", r3_ack, 1);
        chk("t6_rdata", r3_rdata, 16'h1234);
        chk("t6_load_done", r3_mem_load, 0);
        chk("t6_m1_ack", r3_m1_ack, 0);
        r3_req = 0;
        step();
        chk("t6_ack_pulse", r3_ack, 0);
        chk("t6_m1_rdata", r3_m1_rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
